// File: rtl/exp_align_ctrl_if.sv
// Bundles the operand request, shifter and result signals of exp_align_ctrl.
//   master : requester side (drives Start/A/B, provides Sh_Result from the shifter)
//   slave  : exp_align_ctrl side (drives Busy, shifter controls and results)
interface exp_align_ctrl_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 8;

  logic              Start;
  logic [WORD_W-1:0] A;
  logic [WORD_W-1:0] B;
  logic              Busy;
  logic [MANT_W-1:0] Sh_Data;
  logic [EXP_W-1:0]  Sh_Count;
  logic              Sh_Direction;
  logic              Sh_Load;
  logic [MANT_W-1:0] Sh_Result;
  logic              Valid;
  logic [MANT_W-1:0] Mant_Large;
  logic [MANT_W-1:0] Mant_Small;
  logic [EXP_W-1:0]  Exp_Out;
  logic              Sign_Large;
  logic              Eff_Sub;
  logic              Swap;
  logic              Sticky;

  modport master (
    output Start, A, B, Sh_Result,
    input  Busy, Sh_Data, Sh_Count, Sh_Direction, Sh_Load, Valid,
    input  Mant_Large, Mant_Small, Exp_Out, Sign_Large, Eff_Sub, Swap, Sticky
  );

  modport slave (
    input  Start, A, B, Sh_Result,
    output Busy, Sh_Data, Sh_Count, Sh_Direction, Sh_Load, Valid,
    output Mant_Large, Mant_Small, Exp_Out, Sign_Large, Eff_Sub, Swap, Sticky
  );
endinterface

// File: rtl/exp_align_ctrl.sv
// Operand-alignment front end of the single-precision adder.
// Unpacks A/B, orders them by magnitude, drives count_shifter to right-shift
// the smaller mantissa by the exponent difference and presents the aligned
// pair with a one-cycle Valid pulse.
// Ports:
//   Clk   : rising-edge clock
//   Clear : synchronous active-high reset (shared with count_shifter)
//   bus   : exp_align_ctrl_if.slave (request, shifter control, results)
// Parameter SHIFT_LAT: extra shifter cycles beyond Count before Sh_Result is final.
// Optional macro ALIGN_STICKY_EN: builds the shifted-out sticky logic;
// without it Sticky is tied to 0.
module exp_align_ctrl #(
  parameter int unsigned SHIFT_LAT = 1
) (
  input  logic          Clk,
  input  logic          Clear,
  exp_align_ctrl_if.slave bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMP  = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]        state, state_nx;
  logic [WORD_W-1:0] a_q, a_nx, b_q, b_nx;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;
  logic              busy_q, busy_nx;
  logic              valid_q, valid_nx;
  logic              sh_load_q, sh_load_nx;
  logic [MANT_W-1:0] sh_data_q, sh_data_nx;
  logic [EXP_W-1:0]  sh_count_q, sh_count_nx;
  logic [MANT_W-1:0] mant_large_q, mant_large_nx;
  logic [MANT_W-1:0] mant_small_q, mant_small_nx;
  logic [EXP_W-1:0]  exp_out_q, exp_out_nx;
  logic              sign_large_q, sign_large_nx;
  logic              eff_sub_q, eff_sub_nx;
  logic              swap_q, swap_nx;

  // Unpack and order the registered operands
  logic [EXP_W-1:0]  exp_a, exp_b, eff_a, eff_b, e_l, e_s, diff;
  logic [MANT_W-1:0] mant_a, mant_b, m_l, m_s;
  logic              a_wins, s_l;

  always_comb begin
    exp_a  = a_q[30:23];
    exp_b  = b_q[30:23];
    eff_a  = (exp_a == '0) ? EXP_W'(1) : exp_a;
    eff_b  = (exp_b == '0) ? EXP_W'(1) : exp_b;
    mant_a = {|exp_a, a_q[22:0]};
    mant_b = {|exp_b, b_q[22:0]};
    // A wins ties so Swap stays 0 for equal magnitudes
    a_wins = ({eff_a, mant_a} >= {eff_b, mant_b});
    e_l    = a_wins ? eff_a  : eff_b;
    e_s    = a_wins ? eff_b  : eff_a;
    m_l    = a_wins ? mant_a : mant_b;
    m_s    = a_wins ? mant_b : mant_a;
    s_l    = a_wins ? a_q[31] : b_q[31];
    diff   = e_l - e_s;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx      = state;
    a_nx          = a_q;
    b_nx          = b_q;
    wait_cnt_nx   = wait_cnt;
    sh_data_nx    = sh_data_q;
    sh_count_nx   = sh_count_q;
    mant_large_nx = mant_large_q;
    mant_small_nx = mant_small_q;
    exp_out_nx    = exp_out_q;
    sign_large_nx = sign_large_q;
    eff_sub_nx    = eff_sub_q;
    swap_nx       = swap_q;

    case (state)
      IDLE: begin
        if (bus.Start) begin
          a_nx     = bus.A;
          b_nx     = bus.B;
          state_nx = CMP;
        end
      end
      CMP: begin
        mant_large_nx = m_l;
        exp_out_nx    = e_l;
        sign_large_nx = s_l;
        eff_sub_nx    = a_q[31] ^ b_q[31];
        swap_nx       = ~a_wins;
        if (diff == '0) begin
          mant_small_nx = m_s;
          state_nx      = DONE;
        end else if (diff > EXP_W'(23)) begin
          // beyond the shifter's range: everything shifts out
          mant_small_nx = '0;
          state_nx      = DONE;
        end else begin
          // shifter inputs must be valid during the Load cycle itself
          mant_small_nx = '0;
          sh_data_nx    = m_s;
          sh_count_nx   = diff;
          state_nx      = LOAD;
        end
      end
      LOAD: begin
        wait_cnt_nx = CNT_W'(32'(sh_count_q) + SHIFT_LAT - 32'd1);
        state_nx    = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          mant_small_nx = bus.Sh_Result;
          state_nx      = DONE;
        end else begin
          wait_cnt_nx = wait_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx    = (state_nx != IDLE);
    valid_nx   = (state_nx == DONE);
    sh_load_nx = (state_nx == LOAD);
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Clear) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      wait_cnt     <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      sh_load_q    <= 1'b0;
      sh_data_q    <= '0;
      sh_count_q   <= '0;
      mant_large_q <= '0;
      mant_small_q <= '0;
      exp_out_q    <= '0;
      sign_large_q <= 1'b0;
      eff_sub_q    <= 1'b0;
      swap_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      a_q          <= a_nx;
      b_q          <= b_nx;
      wait_cnt     <= wait_cnt_nx;
      busy_q       <= busy_nx;
      valid_q      <= valid_nx;
      sh_load_q    <= sh_load_nx;
      sh_data_q    <= sh_data_nx;
      sh_count_q   <= sh_count_nx;
      mant_large_q <= mant_large_nx;
      mant_small_q <= mant_small_nx;
      exp_out_q    <= exp_out_nx;
      sign_large_q <= sign_large_nx;
      eff_sub_q    <= eff_sub_nx;
      swap_q       <= swap_nx;
    end
  end

`ifdef ALIGN_STICKY_EN
  // Sticky: OR of the smaller-mantissa bits that the alignment shift discards
  logic [MANT_W-1:0] low_mask;
  logic              sticky_cmp, sticky_q;

  always_comb begin
    low_mask = (MANT_W'(1) << diff[4:0]) - MANT_W'(1);
    if (diff == '0)
      sticky_cmp = 1'b0;
    else if (diff > EXP_W'(23))
      sticky_cmp = |m_s;
    else
      sticky_cmp = |(m_s & low_mask);
  end

  always_ff @(posedge Clk) begin
    if (Clear)
      sticky_q <= 1'b0;
    else if (state == CMP)
      sticky_q <= sticky_cmp;
  end

  assign bus.Sticky = sticky_q;
`else
  assign bus.Sticky = 1'b0;
`endif

  assign bus.Busy         = busy_q;
  assign bus.Valid        = valid_q;
  assign bus.Sh_Load      = sh_load_q;
  assign bus.Sh_Data      = sh_data_q;
  assign bus.Sh_Count     = sh_count_q;
  assign bus.Sh_Direction = 1'b0;
  assign bus.Mant_Large   = mant_large_q;
  assign bus.Mant_Small   = mant_small_q;
  assign bus.Exp_Out      = exp_out_q;
  assign bus.Sign_Large   = sign_large_q;
  assign bus.Eff_Sub      = eff_sub_q;
  assign bus.Swap         = swap_q;
endmodule

// File: tb/tb_exp_align_ctrl.sv
// Self-checking bench for exp_align_ctrl: behavioural shifter, cycle-level
// reference model, directed scenarios with literal expectations, random traffic.
module tb_exp_align_ctrl;
  localparam int unsigned SHIFT_LAT = 1;
`ifdef ALIGN_STICKY_EN
  localparam bit STK_ON = 1'b1;
`else
  localparam bit STK_ON = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] ml;
    logic [23:0] ms;
    logic [7:0]  eo;
    logic        sl;
    logic        es;
    logic        sw;
    logic        st;
  } res_t;

  logic Clk = 1'b0;
  logic Clear;
  exp_align_ctrl_if bus();

  exp_align_ctrl #(.SHIFT_LAT(SHIFT_LAT)) dut (
    .Clk  (Clk),
    .Clear(Clear),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int n = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge Clk) n <= n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, n, act, expv);
    end
  endtask

  // Shifter: result is correct only once Count+SHIFT_LAT-1 edges have passed after Load
  logic [23:0] sf_data = '0;
  logic [7:0]  sf_cnt = '0;
  int          sf_age = 0;
  logic        sf_loaded = 1'b0;
  always @(posedge Clk) begin
    if (Clear) sf_loaded <= 1'b0;
    else if (bus.Sh_Load === 1'b1) begin
      sf_loaded <= 1'b1;
      sf_data   <= bus.Sh_Data;
      sf_cnt    <= bus.Sh_Count;
      sf_age    <= 0;
    end else sf_age <= sf_age + 1;
  end
  assign bus.Sh_Result = (sf_loaded && sf_age >= int'(sf_cnt) + int'(SHIFT_LAT) - 1)
                         ? (sf_data >> sf_cnt) : ~(sf_data >> sf_cnt);

  // Reference arithmetic for one operation
  task automatic model_op(input logic [31:0] a, input logic [31:0] b, output res_t r,
                          output int lat, output bit shift, output logic [23:0] sd,
                          output logic [7:0] sc);
    int ea, eb, ma, mb, el, es, ml, ms, d;
    bit a_big;
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    ma = int'({(a[30:23] != 8'd0), a[22:0]});
    mb = int'({(b[30:23] != 8'd0), b[22:0]});
    a_big = (ea > eb) || (ea == eb && ma >= mb);
    el = a_big ? ea : eb;  es = a_big ? eb : ea;
    ml = a_big ? ma : mb;  ms = a_big ? mb : ma;
    d  = el - es;
    r.ml = 24'(ml);
    r.eo = 8'(el);
    r.sl = a_big ? a[31] : b[31];
    r.es = a[31] ^ b[31];
    r.sw = !a_big;
    if (d == 0) begin
      r.ms = 24'(ms); lat = 2; shift = 0; r.st = 1'b0;
    end else if (d > 23) begin
      r.ms = '0; lat = 2; shift = 0; r.st = (ms != 0);
    end else begin
      r.ms = 24'(ms >> d); lat = d + int'(SHIFT_LAT) + 3; shift = 1;
      r.st = ((ms % (1 << d)) != 0);
    end
    if (!STK_ON) r.st = 1'b0;
    sd = 24'(ms);
    sc = 8'(d);
  endtask

  // Cycle-level model: checks every cycle, then absorbs this cycle's inputs
  bit          model_on = 0, pend = 0, nshift = 0, fchk = 0, shchk = 0;
  int          s_cyc = 0, v_cyc = -1, ld_cyc = -1, foff = -1;
  res_t        ef = '0, nf = '0;
  logic [23:0] esd = '0, nsd = '0;
  logic [7:0]  esc = '0, nsc = '0;

  always @(negedge Clk) begin
    int lat;
    if (model_on) begin
      if (pend && n > v_cyc) pend = 0;
      if (n == foff) fchk = 0;
      if (pend && n == v_cyc) begin fchk = 1; ef = nf; shchk = 0; end
      if (pend && nshift && n == ld_cyc) begin shchk = 1; esd = nsd; esc = nsc; end

      chk("busy", 32'(bus.Busy), 32'(pend && n >= s_cyc + 1 && n <= v_cyc));
      chk("valid", 32'(bus.Valid), 32'(pend && n == v_cyc));
      chk("sh_load", 32'(bus.Sh_Load), 32'(pend && nshift && n == ld_cyc));
      chk("sh_dir", 32'(bus.Sh_Direction), 32'd0);
      if (fchk) begin
        chk("mant_large", 32'(bus.Mant_Large), 32'(ef.ml));
        chk("mant_small", 32'(bus.Mant_Small), 32'(ef.ms));
        chk("exp_out", 32'(bus.Exp_Out), 32'(ef.eo));
        chk("sign_large", 32'(bus.Sign_Large), 32'(ef.sl));
        chk("eff_sub", 32'(bus.Eff_Sub), 32'(ef.es));
        chk("swap", 32'(bus.Swap), 32'(ef.sw));
        chk("sticky", 32'(bus.Sticky), 32'(ef.st));
      end
      if (shchk) begin
        chk("sh_data", 32'(bus.Sh_Data), 32'(esd));
        chk("sh_count", 32'(bus.Sh_Count), 32'(esc));
      end
    end

    if (Clear === 1'b1) begin
      model_on = 1; pend = 0; foff = -1;
      fchk = 1; ef = '0; shchk = 1; esd = '0; esc = '0;
    end else if (model_on && bus.Start === 1'b1 && !pend) begin
      model_op(bus.A, bus.B, nf, lat, nshift, nsd, nsc);
      s_cyc = n; v_cyc = n + lat; ld_cyc = n + 2; foff = n + 2;
      pend = 1; shchk = 0;
    end
  end

  // Directed operation with literal expectations
  task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [23:0] eml, input logic [23:0] ems, input logic [7:0] eeo,
                          input bit esw, input bit esl, input bit ees, input bit est,
                          input int elat, input bit eload);
    int sc, lat;
    bit seen_load;
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.A = a; bus.B = b; sc = n;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    lat = -1; seen_load = 0;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      @(negedge Clk);
      if (bus.Sh_Load === 1'b1) seen_load = 1;
      if (bus.Valid === 1'b1) lat = n - sc;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_load_seen"}, 32'(seen_load), 32'(eload));
    chk({nm, "_ml"}, 32'(bus.Mant_Large), 32'(eml));
    chk({nm, "_ms"}, 32'(bus.Mant_Small), 32'(ems));
    chk({nm, "_eo"}, 32'(bus.Exp_Out), 32'(eeo));
    chk({nm, "_swap"}, 32'(bus.Swap), 32'(esw));
    chk({nm, "_sl"}, 32'(bus.Sign_Large), 32'(esl));
    chk({nm, "_es"}, 32'(bus.Eff_Sub), 32'(ees));
    chk({nm, "_st"}, 32'(bus.Sticky), 32'(est));
  endtask

  function automatic logic [31:0] gen_near(input logic [31:0] ref_v);
    logic [31:0] r;
    int e;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: begin
        e = int'(ref_v[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (e < 0) e = 0;
        if (e > 255) e = 255;
        r[30:23] = 8'(e);
      end
      2: r[30:23] = ref_v[30:23];
      default: r[30:23] = 8'd0;
    endcase
    return r;
  endfunction

  initial begin
    int vcount, sc;
    logic [31:0] ra;
    Clear = 1'b1; bus.Start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge Clk);
    #1 Clear = 1'b0;
    @(negedge Clk);
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    chk("reset_valid", 32'(bus.Valid), 32'd0);
    chk("reset_load", 32'(bus.Sh_Load), 32'd0);
    chk("reset_ml", 32'(bus.Mant_Large), 32'd0);

    directed("one_quarter", 32'h3F800000, 32'h3E800000, 24'h800000, 24'h200000, 8'h7F,
             0, 0, 0, 0, 6, 1);
    directed("neg_swap", 32'h3E800000, 32'hBF800000, 24'h800000, 24'h200000, 8'h7F,
             1, 1, 1, 0, 6, 1);
    directed("equal_exp", 32'h40000000, 32'h40400000, 24'hC00000, 24'h800000, 8'h80,
             1, 0, 0, 0, 2, 0);
    directed("diff24", 32'h4B800000, 32'h3F800000, 24'h800000, 24'h000000, 8'h97,
             0, 0, 0, STK_ON, 2, 0);
    directed("sticky_lsb", 32'h3F800000, 32'h3E800001, 24'h800000, 24'h200000, 8'h7F,
             0, 0, 0, STK_ON, 6, 1);

    // Clear in the second WAIT cycle aborts the operation
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.A = 32'h3F800000; bus.B = 32'h3E800000; sc = n;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    while (n < sc + 4) begin @(posedge Clk); #1; end
    Clear = 1'b1;
    @(posedge Clk); #1;
    Clear = 1'b0;
    @(negedge Clk);
    chk("clr_busy", 32'(bus.Busy), 32'd0);
    chk("clr_load", 32'(bus.Sh_Load), 32'd0);
    chk("clr_count", 32'(bus.Sh_Count), 32'd0);
    chk("clr_ml", 32'(bus.Mant_Large), 32'd0);
    vcount = 0;
    repeat (10) begin @(negedge Clk); if (bus.Valid === 1'b1) vcount++; end
    chk("clr_no_valid", 32'(vcount), 32'd0);
    directed("after_clear", 32'h3F800000, 32'h3E800000, 24'h800000, 24'h200000, 8'h7F,
             0, 0, 0, 0, 6, 1);

    // Start pulsed while busy is dropped
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.A = 32'h3F800000; bus.B = 32'h3E800000;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.A = 32'h40000000; bus.B = 32'h40400000;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    vcount = 0;
    repeat (20) begin @(negedge Clk); if (bus.Valid === 1'b1) vcount++; end
    chk("busy_start_one_valid", 32'(vcount), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge Clk); #1;
      Clear = ($urandom_range(0, 99) == 0);
      bus.Start = 1'($urandom_range(0, 1));
      ra = $urandom;
      bus.A = ra;
      bus.B = gen_near(ra);
    end
    @(posedge Clk); #1;
    Clear = 1'b0; bus.Start = 1'b0;
    repeat (60) @(posedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
